adder_rr_arbiter: RTL and testbench

//   Shares one pipelined unsigned adder core among NUM_REQ requesters.

---
 rtl/adder_rr_arbiter.sv | 166 ++++++++++++++++
 tb/tb_adder_rr_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// adder_rr_arbiter
//   Shares one pipelined unsigned adder core among NUM_REQ requesters.
//   A round-robin arbiter picks at most one eligible requester per cycle,
//   latches its operands onto the adder core inputs, tags the operation
//   through the core latency and returns the registered sum to its owner.
//   Each requester may have only one operation outstanding at a time.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active low
//   req_valid  : per-requester request valid
//   req_ready  : per-requester accept, one-hot or zero (combinational grant)
//   req_a/b    : packed operands, requester i at [i*WIDTH +: WIDTH]
//   add_a/b    : registered operands to the adder core
//   add_s      : adder core sum, valid ADD_LATENCY cycles after add_a/add_b
//   rsp_valid  : one-hot single-cycle response strobe
//   rsp_id     : index of the responding requester
//   rsp_sum    : WIDTH+1 bit unsigned sum
// ---------------------------------------------------------------------------
module adder_rr_arbiter #(
    parameter int  NUM_REQ     = 4,
    parameter int  WIDTH       = 8,
    parameter int  ADD_LATENCY = 1,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH:0]           add_s,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH:0]           rsp_sum
);

    // Decode a requester index into a one-hot requester vector.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] oh;
        oh = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(id) == i) begin
                oh[i] = 1'b1;
            end else begin
                oh[i] = 1'b0;
            end
        end
        return oh;
    endfunction

    logic [NUM_REQ-1:0] pending_q,   pending_d;
    logic [ID_W-1:0]    ptr_q,       ptr_d;
    logic [WIDTH-1:0]   add_a_q,     add_a_d;
    logic [WIDTH-1:0]   add_b_q,     add_b_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q,    rsp_id_d;
    logic [WIDTH:0]     rsp_sum_q,   rsp_sum_d;

    // Stage 0 sits alongside add_a/add_b; stage ADD_LATENCY lines up with add_s.
    logic               tag_vld_q [0:ADD_LATENCY];
    logic               tag_vld_d [0:ADD_LATENCY];
    logic [ID_W-1:0]    tag_id_q  [0:ADD_LATENCY];
    logic [ID_W-1:0]    tag_id_d  [0:ADD_LATENCY];

    logic [NUM_REQ-1:0] eligible_s;
    logic [NUM_REQ-1:0] grant_oh_s;
    logic               grant_s;
    logic [ID_W-1:0]    grant_id_s;
    logic [ID_W-1:0]    idx_s;

    // Round-robin search for the first eligible requester starting at ptr.
    always_comb begin
        eligible_s = req_valid & ~pending_q;
        grant_s    = 1'b0;
        grant_id_s = {ID_W{1'b0}};
        idx_s      = {ID_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_s && eligible_s[idx_s]) begin
                grant_s    = 1'b1;
                grant_id_s = idx_s;
            end else begin
                grant_id_s = grant_id_s;
            end
        end
        if (grant_s) begin
            grant_oh_s = onehot(grant_id_s);
        end else begin
            grant_oh_s = {NUM_REQ{1'b0}};
        end
    end

    // Next-state for operands, pointer, pending set, tag pipe and response.
    always_comb begin
        // A requester cannot be granted while pending, so set and clear never collide.
        pending_d = (pending_q & ~rsp_valid_q) | grant_oh_s;

        if (grant_s) begin
            add_a_d = req_a[int'(grant_id_s)*WIDTH +: WIDTH];
            add_b_d = req_b[int'(grant_id_s)*WIDTH +: WIDTH];
            ptr_d   = ID_W'((int'(grant_id_s) + 1) % NUM_REQ);
        end else begin
            add_a_d = add_a_q;
            add_b_d = add_b_q;
            ptr_d   = ptr_q;
        end

        tag_vld_d[0] = grant_s;
        tag_id_d[0]  = grant_id_s;
        for (int s = 1; s <= ADD_LATENCY; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end

        if (tag_vld_q[ADD_LATENCY]) begin
            rsp_valid_d = onehot(tag_id_q[ADD_LATENCY]);
            rsp_id_d    = tag_id_q[ADD_LATENCY];
            rsp_sum_d   = add_s;
        end else begin
            rsp_valid_d = {NUM_REQ{1'b0}};
            rsp_id_d    = rsp_id_q;
            rsp_sum_d   = rsp_sum_q;
        end
    end

    // State registers; reset discards every in-flight operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q   <= {NUM_REQ{1'b0}};
            ptr_q       <= {ID_W{1'b0}};
            add_a_q     <= {WIDTH{1'b0}};
            add_b_q     <= {WIDTH{1'b0}};
            rsp_valid_q <= {NUM_REQ{1'b0}};
            rsp_id_q    <= {ID_W{1'b0}};
            rsp_sum_q   <= {(WIDTH+1){1'b0}};
            for (int s = 0; s <= ADD_LATENCY; s++) begin
                tag_vld_q[s] <= 1'b0;
                tag_id_q[s]  <= {ID_W{1'b0}};
            end
        end else begin
            pending_q   <= pending_d;
            ptr_q       <= ptr_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            for (int s = 0; s <= ADD_LATENCY; s++) begin
                tag_vld_q[s] <= tag_vld_d[s];
                tag_id_q[s]  <= tag_id_d[s];
            end
        end
    end

    assign req_ready = grant_oh_s;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_rr_arbiter
//   Drives directed and random requests, predicts every grant from the
//   round-robin rules and queues the expected response (id, sum, cycle).
//   A separate monitor pops and compares whenever rsp_valid is asserted.
//   The adder core is modelled here as a plain ADD_LATENCY-deep pipeline.
// ---------------------------------------------------------------------------
module tb_adder_rr_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int L   = 1;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W:0]     add_s;
    logic [N-1:0]   rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [W:0]     rsp_sum;

    adder_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .ADD_LATENCY(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_s     (add_s),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum)
    );

    always #5 clk = ~clk;

    // Adder core: L register stages from operands to sum.
    logic [W:0] core_pipe [0:L-1];
    always @(posedge clk) begin
        core_pipe[0] <= {1'b0, add_a} + {1'b0, add_b};
        for (int i = 1; i < L; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign add_s = core_pipe[L-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int         id;
        logic [W:0] sum;
        int         due;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state: next search start, and per requester the
    // cycle its response is due (pending until the end of that cycle).
    int ptr_m;
    bit busy_m  [N];
    int until_m [N];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    endtask

    task automatic model_reset();
        exp_q.delete();
        ptr_m = 0;
        for (int i = 0; i < N; i++) begin
            busy_m[i]  = 1'b0;
            until_m[i] = 0;
        end
    endtask

    // One clock cycle: predict and check the grant, record the op, advance.
    task automatic step();
        logic [N-1:0] exp_ready;
        int           g;
        exp_t         e;
        @(negedge clk);
        exp_ready = '0;
        g = -1;
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (ptr_m + k) % N;
                if (g < 0 && req_valid[idx] && (!busy_m[idx] || until_m[idx] < cyc)) g = idx;
            end
            if (g >= 0) exp_ready[g] = 1'b1;
        end
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        if (g >= 0) begin
            e.id  = g;
            e.sum = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]};
            e.due = cyc + L + 2;
            exp_q.push_back(e);
            busy_m[g]  = 1'b1;
            until_m[g] = e.due;
            ptr_m      = (g + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) step();
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) set_ops(i, W'($urandom), W'($urandom));
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_add_a"},     64'(add_a),     64'd0);
        chk({tag, "_add_b"},     64'(add_b),     64'd0);
        chk({tag, "_rsp_id"},    64'(rsp_id),    64'd0);
        chk({tag, "_rsp_sum"},   64'(rsp_sum),   64'd0);
    endtask

    // Monitor: every response must match the oldest expected op, on time.
    exp_t m_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            chk("rsp_missing_due", 64'(cyc), 64'(exp_q[0].due));
            void'(exp_q.pop_front());
        end
        if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                m_e = exp_q.pop_front();
                chk("rsp_valid_onehot", 64'(rsp_valid), 64'(1) << m_e.id);
                chk("rsp_id",           64'(rsp_id),    64'(m_e.id));
                chk("rsp_sum",          64'(rsp_sum),   64'(m_e.sum));
                chk("rsp_cycle",        64'(cyc),       64'(m_e.due));
            end
        end
    end

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b1;

        // Single request 200+100.
        set_ops(0, 8'd200, 8'd100);
        req_valid = 4'b0001;
        step();
        idle(5);

        // Park the pointer at 0, then all four requesters held valid.
        req_valid = 4'b1000;
        step();
        idle(5);
        rand_ops();
        req_valid = 4'b1111;
        repeat (10) step();
        idle(6);

        // Requester 2 alone, held high: re-accepted every fourth cycle.
        set_ops(2, 8'd17, 8'd42);
        req_valid = 4'b0100;
        repeat (9) step();
        idle(6);

        // Operand extremes.
        set_ops(0, 8'd255, 8'd255);
        set_ops(1, 8'd0,   8'd0);
        set_ops(3, 8'd128, 8'd128);
        req_valid = 4'b1011;
        repeat (3) step();
        idle(6);

        // Fairness: pointer at 3 after granting 2, then 0 and 3 contend.
        req_valid = 4'b0100;
        step();
        idle(5);
        req_valid = 4'b1001;
        repeat (6) step();
        idle(6);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            req_valid = N'($urandom_range(0, (1 << N) - 1));
            rand_ops();
            step();
        end
        idle(8);

        // Reset with operations in flight.
        rand_ops();
        req_valid = 4'b1110;
        repeat (3) step();
        #2;
        rst       = 1'b0;
        req_valid = '0;
        #1;
        chk_outputs_zero("midop_reset");
        model_reset();
        repeat (2) step();
        rst = 1'b1;
        idle(6);
        req_valid = 4'b1110;
        repeat (4) step();
        idle(8);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
